// File: rtl/movimento_executor.sv
// movimento_executor: sequences the gripper, base and tilt servos of a cube
// handling arm through a fixed table of steps for each move code.
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous, active-high reset
//   aciona         level request to run the move in codigo (needs a low
//                  level seen since the last accepted move to rearm)
//   codigo[2:0]    move code, latched when a move is accepted
//   parar          synchronous abort of the current move
//   garra_fechada  gripper command (1 = closed)
//   pos_base[1:0]  base angle (00 = 0, 01 = 90, 10 = 180 deg)
//   virar          tilt arm command
//   fim_movimento  one-cycle completion pulse
//   ocupado        high while a move is loading or stepping
//   erro           one-cycle pulse for an invalid move code
//   db_estado[3:0] debug encoding of the controller state
//
// The fim_movimento/erro pulses are registered while the controller sits in
// FIM/ERRO, so they appear in the cycle after that state. This gives an
// acceptance-to-pulse latency of 2 + N*T_PASSO cycles.

module movimento_executor #(
  parameter int unsigned T_PASSO = 25000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       aciona,
  input  logic [2:0] codigo,
  input  logic       parar,
  output logic       garra_fechada,
  output logic [1:0] pos_base,
  output logic       virar,
  output logic       fim_movimento,
  output logic       ocupado,
  output logic       erro,
  output logic [3:0] db_estado
);

  localparam int unsigned TW = (T_PASSO > 1) ? $clog2(T_PASSO) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(T_PASSO - 1);

  localparam logic [2:0] COD_ULTIMO_VALIDO = 3'b100;
  localparam logic [3:0] DB_INVALIDO       = 4'b1111;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    PASSO   = 3'd2,
    FIM     = 3'd3,
    ERRO    = 3'd4
  } state_t;

  state_t           state_q;
  logic [2:0]       codigo_q;
  logic [1:0]       idx_q;
  logic [TW-1:0]    timer_q;
  logic             rearm_q;
  logic [3:0]       saida_q;      // {garra, pos_base[1:0], virar}
  logic             fim_q;
  logic             erro_q;
  logic             ocupado_q;
  logic [3:0]       db_q;

  logic             aceita_c;
  logic             expira_c;
  logic             ultimo_c;
  logic [1:0]       idx_d;

  // Servo command word for a given move code and step index.
  function automatic logic [3:0] step_val(input logic [2:0] c, input logic [1:0] i);
    logic [3:0] v;
    v = 4'b0000;
    case ({c, i})
      {3'b001, 2'd0}: v = 4'b1000;
      {3'b001, 2'd1}: v = 4'b1010;
      {3'b001, 2'd2}: v = 4'b0010;
      {3'b010, 2'd0}: v = 4'b0010;
      {3'b010, 2'd1}: v = 4'b1010;
      {3'b010, 2'd2}: v = 4'b1000;
      {3'b011, 2'd0}: v = 4'b1000;
      {3'b011, 2'd1}: v = 4'b1100;
      {3'b011, 2'd2}: v = 4'b0100;
      {3'b100, 2'd0}: v = 4'b0001;
      default:        v = 4'b0000;
    endcase
    return v;
  endfunction

  // Index of the final step of each move code.
  function automatic logic [1:0] last_idx(input logic [2:0] c);
    logic [1:0] n;
    case (c)
      3'b001, 3'b010, 3'b011: n = 2'd3;
      3'b100:                 n = 2'd1;
      default:                n = 2'd0;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] db_of(input state_t s);
    return {1'b0, 3'(s)};
  endfunction

  // Acceptance needs a rearm (aciona seen low) and no abort this cycle.
  assign aceita_c = aciona && rearm_q && !parar;
  assign expira_c = (timer_q == T_LAST);
  assign ultimo_c = (idx_q == last_idx(codigo_q));
  assign idx_d    = idx_q + 2'd1;

  // Controller state, step sequencing and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= OCIOSO;
      codigo_q  <= 3'b000;
      idx_q     <= 2'd0;
      timer_q   <= '0;
      rearm_q   <= 1'b0;
      saida_q   <= 4'b0000;
      fim_q     <= 1'b0;
      erro_q    <= 1'b0;
      ocupado_q <= 1'b0;
      db_q      <= 4'b0000;
    end else begin
      fim_q  <= 1'b0;
      erro_q <= 1'b0;
      if (!aciona) begin
        rearm_q <= 1'b1;
      end

      case (state_q)
        OCIOSO: begin
          if (aceita_c) begin
            state_q   <= CARREGA;
            db_q      <= db_of(CARREGA);
            codigo_q  <= codigo;
            rearm_q   <= 1'b0;
            ocupado_q <= 1'b1;
          end
        end

        CARREGA: begin
          if (parar) begin
            state_q   <= OCIOSO;
            db_q      <= db_of(OCIOSO);
            saida_q   <= 4'b0000;
            ocupado_q <= 1'b0;
            idx_q     <= 2'd0;
            timer_q   <= '0;
          end else if (codigo_q <= COD_ULTIMO_VALIDO) begin
            state_q <= PASSO;
            db_q    <= db_of(PASSO);
            idx_q   <= 2'd0;
            timer_q <= '0;
            saida_q <= step_val(codigo_q, 2'd0);
          end else begin
            state_q   <= ERRO;
            db_q      <= db_of(ERRO);
            ocupado_q <= 1'b0;
          end
        end

        PASSO: begin
          // Abort wins over the step timer expiring in the same cycle.
          if (parar) begin
            state_q   <= OCIOSO;
            db_q      <= db_of(OCIOSO);
            saida_q   <= 4'b0000;
            ocupado_q <= 1'b0;
            idx_q     <= 2'd0;
            timer_q   <= '0;
          end else if (expira_c) begin
            if (ultimo_c) begin
              state_q   <= FIM;
              db_q      <= db_of(FIM);
              ocupado_q <= 1'b0;
            end else begin
              idx_q   <= idx_d;
              timer_q <= '0;
              saida_q <= step_val(codigo_q, idx_d);
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        FIM: begin
          fim_q   <= 1'b1;
          state_q <= OCIOSO;
          db_q    <= db_of(OCIOSO);
        end

        ERRO: begin
          fim_q   <= 1'b1;
          erro_q  <= 1'b1;
          state_q <= OCIOSO;
          db_q    <= db_of(OCIOSO);
        end

        default: begin
          state_q   <= OCIOSO;
          db_q      <= DB_INVALIDO;
          ocupado_q <= 1'b0;
        end
      endcase
    end
  end

  assign garra_fechada = saida_q[3];
  assign pos_base      = saida_q[2:1];
  assign virar         = saida_q[0];
  assign fim_movimento = fim_q;
  assign erro          = erro_q;
  assign ocupado       = ocupado_q;
  assign db_estado     = db_q;

endmodule

// File: doc/movimento_executor.md
MOVIMENTO_EXECUTOR -- requirements
Module: movimento_executor

Interface
REQ-001 Parameter T_PASSO, default 25000000, number of clock cycles each servo step is held (minimum 2).
REQ-002 clock  input  1  system clock; all state changes on the rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 aciona  input  1  level request from the main control unit to execute the move in codigo.
REQ-005 codigo  input  3  move code, sampled only when a move is accepted.
REQ-006 parar  input  1  synchronous abort of the current move.
REQ-007 garra_fechada  output  1  gripper servo command: 1 = closed, 0 = open.
REQ-008 pos_base  output  2  base servo angle: 00 = 0 deg, 01 = 90 deg, 10 = 180 deg; 11 is never driven.
REQ-009 virar  output  1  tilt arm command: 1 = tilt cube.
REQ-010 fim_movimento  output  1  one-cycle completion pulse.
REQ-011 ocupado  output  1  high while a move is in progress (CARREGA or PASSO).
REQ-012 erro  output  1  one-cycle pulse on an invalid code.
REQ-013 db_estado  output  4  debug encoding of the current state.

Function
REQ-014 The states SHALL be OCIOSO=0000, CARREGA=0001, PASSO=0010, FIM=0011 and ERRO=0100; any other state SHALL go to OCIOSO with db_estado=1111.
REQ-015 The rearm flag SHALL be set whenever aciona=0 and cleared when a move is accepted.
- A move is accepted in OCIOSO only when aciona=1 and rearm=1.
- aciona held high across fim_movimento therefore never retriggers a move.
REQ-016 On acceptance, codigo SHALL be latched and the next state SHALL be CARREGA.
- Valid codes (000-100) go CARREGA -> PASSO with step index 0 and the step timer at 0.
- Invalid codes (101-111) go CARREGA -> ERRO.
REQ-017 Step table, given as (garra_fechada, pos_base, virar) per step; these values are registered and drive the outputs throughout PASSO:
- 000 HOME: (0,00,0).
- 001 HORARIO: (1,00,0) (1,01,0) (0,01,0) (0,00,0).
- 010 ANTI: (0,01,0) (1,01,0) (1,00,0) (0,00,0).
- 011 DUPLO: (1,00,0) (1,10,0) (0,10,0) (0,00,0).
- 100 TOMBA: (0,00,1) (0,00,0).
REQ-018 Each step SHALL hold its outputs for exactly T_PASSO cycles.
- When the timer reaches T_PASSO-1: if it is the last step, go to FIM; otherwise increment the step index, clear the timer and stay in PASSO.
REQ-019 FIM SHALL last one cycle with fim_movimento=1, then go to OCIOSO.
REQ-020 ERRO SHALL last one cycle with erro=1, fim_movimento=1 and outputs unchanged, then go to OCIOSO.
REQ-021 Latency from the acceptance edge to the fim_movimento pulse SHALL be 2 + N*T_PASSO cycles, where N is the step count of the code.
REQ-022 Outputs SHALL hold the last step values in OCIOSO.
REQ-023 parar=1 in CARREGA or PASSO SHALL force the next state to OCIOSO.
- Outputs go to (0,00,0).
- No fim_movimento pulse is generated.
- parar has priority over timer expiry.
- parar in OCIOSO SHALL block acceptance that cycle.
REQ-024 aciona and codigo changes during CARREGA or PASSO SHALL be ignored.
REQ-025 The timer width SHALL be ceil(log2(T_PASSO)) bits; the step index SHALL be 2 bits and never exceed N-1.

Reset
REQ-026 Reset SHALL take effect immediately, including mid-move, with:
- state OCIOSO;
- garra_fechada=0, pos_base=00, virar=0;
- fim_movimento=0, erro=0, ocupado=0;
- db_estado=0000;
- timer=0, index=0, rearm=0.
REQ-027 After reset, a move SHALL be accepted only after aciona has been sampled low at least once.

Verification (T_PASSO=4)
REQ-028 aciona low, then held high with codigo=001 -> gripper closes, then pos_base 01 for 4 cycles, then gripper opens, then pos_base 00; each step lasts 4 cycles; fim_movimento pulses exactly once, 18 cycles after acceptance.
REQ-029 codigo=100 -> virar=1 for exactly 4 cycles, then 0; fim_movimento pulses 10 cycles after acceptance.
REQ-030 codigo=110 -> erro and fim_movimento high in the same single cycle (2 cycles after acceptance); outputs are unchanged.
REQ-031 aciona held high continuously through two fim_movimento pulses' worth of time -> only one move executes; after aciona is dropped for 1 cycle and raised again, a second move executes.
REQ-032 parar asserted in step 2 of 011 (pos_base=10) -> the next cycle shows (0,00,0) and OCIOSO, with no fim_movimento pulse.
REQ-033 reset asserted mid-PASSO of 010 -> outputs go to (0,00,0) and db_estado to 0000 without waiting for a clock edge.
